// File: rtl/fft_peak_picker.sv
// fft_peak_picker: per-band peak detector on the FFT magnitude stream.
// Tracks the lower half of each frame in bands of 2**BAND_SHIFT bins and
// queues (band, bin, magnitude) records above THRESHOLD in a show-ahead FIFO.
// Optional build macro: PEAK_DC_SKIP_EN -- bin 0 never becomes a peak candidate.
module fft_peak_picker #(
    parameter int unsigned FFT_LENGTH = 1024,
    parameter int unsigned BAND_SHIFT = 4,
    parameter logic [15:0] THRESHOLD  = 16'd64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      sync_i,
    input  logic [15:0]                               magnitude_i,
    input  logic                                      magnitude_ready_i,
    output logic                                      peak_valid_o,
    input  logic                                      peak_ready_i,
    output logic [$clog2(FFT_LENGTH)-BAND_SHIFT-2:0]  peak_band_o,
    output logic [$clog2(FFT_LENGTH)-1:0]             peak_bin_o,
    output logic [15:0]                               peak_mag_o,
    output logic                                      frame_done_o,
    output logic                                      overflow_o
);

    localparam int unsigned BW  = $clog2(FFT_LENGTH);
    localparam int unsigned NBW = BW - 1 - BAND_SHIFT;
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);

    // Bin counter and band accumulator
    logic [BW-1:0]  r_bin;
    logic [15:0]    r_max;
    logic [BW-1:0]  r_arg;
    logic           r_band_valid;
    logic           r_frame_done;

    // Peak FIFO storage and bookkeeping
    logic [NBW-1:0] r_mem_band [FIFO_DEPTH];
    logic [BW-1:0]  r_mem_bin  [FIFO_DEPTH];
    logic [15:0]    r_mem_mag  [FIFO_DEPTH];
    logic [PW-1:0]  r_wr;
    logic [PW-1:0]  r_rd;
    logic [PW:0]    r_count;
    logic           r_overflow;

    logic [BW-1:0]  w_bin;
    logic           w_track;
    logic           w_acc_valid;
    logic           w_load;
    logic           w_close;
    logic [15:0]    w_cand_max;
    logic [BW-1:0]  w_cand_arg;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_push_ok;

    // Current bin index, peak candidate and FIFO handshake decisions
    always_comb begin
        // sync_i realigns the frame, so a coincident sample is bin 0 and any
        // partially accumulated band is treated as already cleared.
        w_bin       = sync_i ? '0 : r_bin;
        w_acc_valid = r_band_valid && !sync_i;
        w_track     = magnitude_ready_i && !w_bin[BW-1];
`ifdef PEAK_DC_SKIP_EN
        if (w_bin == '0) begin
            w_track = 1'b0;
        end
`endif
        w_load     = w_track && (!w_acc_valid || (w_bin[BAND_SHIFT-1:0] == '0) ||
                                 (magnitude_i > r_max));
        w_cand_max = w_load ? magnitude_i : r_max;
        w_cand_arg = w_load ? w_bin : r_arg;
        w_close    = w_track && (&w_bin[BAND_SHIFT-1:0]);
        w_push     = w_close && (w_cand_max > THRESHOLD);
        w_pop      = (r_count != '0) && peak_ready_i;
        w_full     = (r_count == (PW+1)'(FIFO_DEPTH));
        w_push_ok  = w_push && (!w_full || w_pop);
    end

    // Bin counting, band max/argmax tracking and frame-done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin        <= '0;
            r_max        <= '0;
            r_arg        <= '0;
            r_band_valid <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= magnitude_ready_i && (w_bin == BW'(FFT_LENGTH - 1));
            if (magnitude_ready_i) begin
                r_bin <= w_bin + BW'(1);
            end else if (sync_i) begin
                r_bin <= '0;
            end
            if (w_close || (sync_i && !w_load)) begin
                r_max        <= '0;
                r_arg        <= '0;
                r_band_valid <= 1'b0;
            end else if (w_load) begin
                r_max        <= magnitude_i;
                r_arg        <= w_bin;
                r_band_valid <= 1'b1;
            end
        end
    end

    // Peak FIFO: push on band close, pop on valid/ready, sticky overflow on drop
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_band[i] <= '0;
                r_mem_bin[i]  <= '0;
                r_mem_mag[i]  <= '0;
            end
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem_band[r_wr] <= w_bin[BW-2:BAND_SHIFT];
                r_mem_bin[r_wr]  <= w_cand_arg;
                r_mem_mag[r_wr]  <= w_cand_max;
                r_wr             <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + (PW+1)'(1);
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - (PW+1)'(1);
            end
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign peak_valid_o = (r_count != '0);
    assign peak_band_o  = r_mem_band[r_rd];
    assign peak_bin_o   = r_mem_bin[r_rd];
    assign peak_mag_o   = r_mem_mag[r_rd];
    assign frame_done_o = r_frame_done;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_fft_peak_picker.sv
// Self-checking bench for fft_peak_picker: table-driven frames plus
// hand-written sequences; expected peak records go into a scoreboard queue.
module tb_fft_peak_picker;

    logic        clk = 1'b0;
    logic        reset;
    logic        sync_i;
    logic [15:0] magnitude_i;
    logic        magnitude_ready_i;
    logic        peak_valid_o;
    logic        peak_ready_i;
    logic [4:0]  peak_band_o;
    logic [9:0]  peak_bin_o;
    logic [15:0] peak_mag_o;
    logic        frame_done_o;
    logic        overflow_o;

    always #5 clk = ~clk;

    fft_peak_picker #(
        .FFT_LENGTH(1024),
        .BAND_SHIFT(4),
        .THRESHOLD (16'd64),
        .FIFO_DEPTH(4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .sync_i           (sync_i),
        .magnitude_i      (magnitude_i),
        .magnitude_ready_i(magnitude_ready_i),
        .peak_valid_o     (peak_valid_o),
        .peak_ready_i     (peak_ready_i),
        .peak_band_o      (peak_band_o),
        .peak_bin_o       (peak_bin_o),
        .peak_mag_o       (peak_mag_o),
        .frame_done_o     (frame_done_o),
        .overflow_o       (overflow_o)
    );

    typedef struct packed {
        logic [4:0]  band;
        logic [9:0]  bin;
        logic [15:0] mag;
    } rec_t;

    typedef struct packed {
        logic [2:0]        nt;
        logic [3:0][9:0]   tbin;
        logic [3:0][15:0]  tmag;
        logic [2:0]        ne;
        logic [3:0][4:0]   eband;
        logic [3:0][9:0]   ebin;
        logic [3:0][15:0]  emag;
    } vec_t;

    rec_t        sb[$];
    vec_t        vecs[3];
    logic [15:0] frame[1024];
    int          checks   = 0;
    int          errors   = 0;
    int          fd_count = 0;
    int          pops     = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_rec(input int band, input int bin, input int mag);
        rec_t r;
        r.band = 5'(band);
        r.bin  = 10'(bin);
        r.mag  = 16'(mag);
        sb.push_back(r);
    endtask

    task automatic send(input logic [15:0] m, input logic s);
        magnitude_ready_i = 1'b1;
        magnitude_i       = m;
        sync_i            = s;
        @(posedge clk);
        #1;
        magnitude_ready_i = 1'b0;
        magnitude_i       = '0;
        sync_i            = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 1024; i++) frame[i] = '0;
    endtask

    task automatic run_frame(input bit sync_first);
        for (int i = 0; i < 1024; i++) send(frame[i], sync_first && (i == 0));
        chk("frame_done_pulse", int'(frame_done_o), 1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 80 && sb.size() != 0; i++) idle(1);
        chk(name, sb.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, int'(peak_valid_o), 0);
        chk({tag, "_band"}, int'(peak_band_o), 0);
        chk({tag, "_bin"}, int'(peak_bin_o), 0);
        chk({tag, "_mag"}, int'(peak_mag_o), 0);
        chk({tag, "_frame_done"}, int'(frame_done_o), 0);
        chk({tag, "_overflow"}, int'(overflow_o), 0);
    endtask

    // Scoreboard consumer: every accepted head record is compared with the queue
    always @(negedge clk) begin
        if (!reset && peak_valid_o && peak_ready_i) begin
            rec_t e;
            pops++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_peak: got band=%0d bin=%0d mag=%0d expected no record",
                         peak_band_o, peak_bin_o, peak_mag_o);
            end else begin
                e = sb.pop_front();
                if (peak_band_o != e.band || peak_bin_o != e.bin || peak_mag_o != e.mag) begin
                    errors++;
                    $display("FAIL peak_record: got band=%0d bin=%0d mag=%0d expected band=%0d bin=%0d mag=%0d",
                             peak_band_o, peak_bin_o, peak_mag_o, e.band, e.bin, e.mag);
                end
            end
        end
        if (frame_done_o) fd_count++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int p0;
        reset             = 1'b1;
        sync_i            = 1'b0;
        magnitude_i       = '0;
        magnitude_ready_i = 1'b0;
        peak_ready_i      = 1'b1;
        idle(3);
        chk_all_zero("reset");
        reset = 1'b0;
        idle(2);

        // Frame vectors: tones, tie/threshold, band-edge bins 0 and 511
        vecs[0] = '0;
        vecs[0].nt = 4;
        vecs[0].tbin[0] = 8;    vecs[0].tmag[0] = 500;
        vecs[0].tbin[1] = 19;   vecs[0].tmag[1] = 400;
        vecs[0].tbin[2] = 30;   vecs[0].tmag[2] = 600;
        vecs[0].tbin[3] = 1016; vecs[0].tmag[3] = 900;
        vecs[0].ne = 2;
        vecs[0].eband[0] = 0; vecs[0].ebin[0] = 8;  vecs[0].emag[0] = 500;
        vecs[0].eband[1] = 1; vecs[0].ebin[1] = 30; vecs[0].emag[1] = 600;

        vecs[1] = '0;
        vecs[1].nt = 3;
        vecs[1].tbin[0] = 33; vecs[1].tmag[0] = 200;
        vecs[1].tbin[1] = 40; vecs[1].tmag[1] = 200;
        vecs[1].tbin[2] = 50; vecs[1].tmag[2] = 64;
        vecs[1].ne = 1;
        vecs[1].eband[0] = 2; vecs[1].ebin[0] = 33; vecs[1].emag[0] = 200;

        vecs[2] = '0;
        vecs[2].nt = 2;
        vecs[2].tbin[0] = 0;   vecs[2].tmag[0] = 65;
        vecs[2].tbin[1] = 511; vecs[2].tmag[1] = 65;
`ifdef PEAK_DC_SKIP_EN
        vecs[2].ne = 1;
        vecs[2].eband[0] = 31; vecs[2].ebin[0] = 511; vecs[2].emag[0] = 65;
`else
        vecs[2].ne = 2;
        vecs[2].eband[0] = 0;  vecs[2].ebin[0] = 0;   vecs[2].emag[0] = 65;
        vecs[2].eband[1] = 31; vecs[2].ebin[1] = 511; vecs[2].emag[1] = 65;
`endif

        for (int v = 0; v < 3; v++) begin
            clear_frame();
            for (int t = 0; t < int'(vecs[v].nt); t++) frame[vecs[v].tbin[t]] = vecs[v].tmag[t];
            for (int e = 0; e < int'(vecs[v].ne); e++)
                expect_rec(int'(vecs[v].eband[e]), int'(vecs[v].ebin[e]), int'(vecs[v].emag[e]));
            f0 = fd_count;
            run_frame(1'b0);
            idle(1);
            chk("frame_done_clear", int'(frame_done_o), 0);
            drain("vec_drained");
            chk("frame_done_once", fd_count - f0, 1);
            chk("vec_no_overflow", int'(overflow_o), 0);
        end

        // Push latency with an empty FIFO, then 37 bins and a lone sync pulse
        expect_rec(0, 3, 99);
        for (int i = 0; i < 16; i++) begin
            send((i == 3) ? 16'd99 : 16'd0, 1'b0);
            if (i == 14) chk("latency_pre", int'(peak_valid_o), 0);
        end
        chk("latency_valid", int'(peak_valid_o), 1);
        chk("latency_head_bin", int'(peak_bin_o), 3);
        for (int i = 16; i < 37; i++) send(16'd0, 1'b0);
        sync_i = 1'b1;
        idle(1);
        sync_i = 1'b0;
        clear_frame();
        frame[5] = 300;
        expect_rec(0, 5, 300);
        run_frame(1'b0);
        drain("sync_drained");

        // sync_i coinciding with a sample makes that sample bin 0
        for (int i = 0; i < 10; i++) send(16'd0, 1'b0);
        clear_frame();
        frame[0]  = 200;
        frame[17] = 150;
`ifndef PEAK_DC_SKIP_EN
        expect_rec(0, 0, 200);
`endif
        expect_rec(1, 17, 150);
        run_frame(1'b1);
        drain("sync_coincident_drained");

        // Backpressure: FIFO fills with bands 0..3, band 4 onwards dropped
        peak_ready_i = 1'b0;
        clear_frame();
        for (int k = 0; k < 32; k++) frame[k*16+7] = 100;
        for (int k = 0; k < 4; k++) expect_rec(k, k*16+7, 100);
        for (int i = 0; i < 1024; i++) begin
            send(frame[i], 1'b0);
            if (i == 63) chk("ovf_before_drop", int'(overflow_o), 0);
            if (i == 79) chk("ovf_after_drop", int'(overflow_o), 1);
        end
        chk("bp_head_valid", int'(peak_valid_o), 1);
        chk("bp_head_band", int'(peak_band_o), 0);
        chk("bp_head_bin", int'(peak_bin_o), 7);
        peak_ready_i = 1'b1;
        drain("bp_drained");
        idle(1);
        chk("bp_empty", int'(peak_valid_o), 0);
        chk("ovf_sticky", int'(overflow_o), 1);

        // Reset at bin 37 discards the queued record and the partial band
        peak_ready_i = 1'b0;
        clear_frame();
        frame[5] = 300;
        for (int i = 0; i < 37; i++) send(frame[i], 1'b0);
        chk("rst_pre_valid", int'(peak_valid_o), 1);
        reset             = 1'b1;
        magnitude_ready_i = 1'b1;
        @(posedge clk);
        #1;
        magnitude_ready_i = 1'b0;
        chk_all_zero("mid_reset");
        reset        = 1'b0;
        peak_ready_i = 1'b1;
        idle(1);
        expect_rec(0, 5, 300);
        run_frame(1'b0);
        drain("post_reset_drained");

        // Two back-to-back frames, one peak per band, mirror-half noise
        clear_frame();
        frame[0]   = 1000;
        frame[1]   = 70;
        frame[600] = 5000;
        for (int k = 1; k < 32; k++) frame[k*16+3] = 16'(100 + k);
        for (int f = 0; f < 2; f++) begin
`ifdef PEAK_DC_SKIP_EN
            expect_rec(0, 1, 70);
`else
            expect_rec(0, 0, 1000);
`endif
            for (int k = 1; k < 32; k++) expect_rec(k, k*16+3, 100 + k);
        end
        f0 = fd_count;
        p0 = pops;
        run_frame(1'b0);
        run_frame(1'b0);
        drain("b2b_drained");
        chk("b2b_frame_done", fd_count - f0, 2);
        chk("b2b_records", pops - p0, 64);
        chk("b2b_no_overflow", int'(overflow_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_peak_picker.md
Name: fft_peak_picker

Overview:
- Consumer of the FFT core's magnitude stream (`magnitude` / `magnitude_ready`). It sits downstream of the FFT in the fingerprint path.
- Counts bins per frame and ignores the mirrored upper half.
- Groups the lower-half bins into equal-width bands and tracks the maximum magnitude per band.
- At each band close, pushes a (band, bin, magnitude) peak record into a small output FIFO with a valid/ready handshake.

Parameters:
- FFT_LENGTH, 1024, bins per frame; power of two.
- BAND_SHIFT, 4, log2 of bins per band; default gives 16 bins/band and 32 bands over bins 0..511.
- THRESHOLD, 16'd64, a peak is emitted only if its magnitude is strictly greater than this.
- FIFO_DEPTH, 4, peak FIFO entries; power of two, >= 2.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high.
- sync_i, input, 1, one-cycle pulse that forces the bin counter to 0 (frame realign).
- magnitude_i, input, 16, unsigned bin magnitude.
- magnitude_ready_i, input, 1, qualifies magnitude_i; one bin per asserted cycle.
- peak_valid_o, output, 1, FIFO head is valid.
- peak_ready_i, input, 1, consumer accepts the head when it is high together with peak_valid_o.
- peak_band_o, output, log2(FFT_LENGTH)-1-BAND_SHIFT, band index of the head record.
- peak_bin_o, output, log2(FFT_LENGTH), bin index of the head record.
- peak_mag_o, output, 16, magnitude of the head record.
- frame_done_o, output, 1, one-cycle pulse after bin FFT_LENGTH-1 is accepted.
- overflow_o, output, 1, sticky; set when a peak is dropped because the FIFO is full.

Behaviour:
- Reset:
  - Bin counter, band max, band argmax, band-valid flag and FIFO pointers/count go to 0.
  - peak_valid_o=0, frame_done_o=0, overflow_o=0; peak_* data outputs=0.
  - Reset mid-frame discards the partial band and all FIFO contents.
- Bin counter:
  - log2(FFT_LENGTH) bits; increments on each magnitude_ready_i and wraps FFT_LENGTH-1 -> 0.
  - sync_i has priority: the counter goes to 0 and the band accumulator clears.
  - If magnitude_ready_i coincides with sync_i, that sample is taken as bin 0.
- Bins >= FFT_LENGTH/2 (mirror half) are counted but ignored for peak tracking.
- Band accumulation, per accepted lower-half bin b:
  - If b is the first bin of its band, or magnitude_i > band max, load max=magnitude_i and argmax=b.
  - Strict compare, so on ties the lowest bin wins.
- Band close on the bin where b[BAND_SHIFT-1:0] is all ones, with b < FFT_LENGTH/2:
  - Candidate = (b>>BAND_SHIFT, argmax, max), computed including the current bin, same cycle.
  - If candidate max > THRESHOLD, push it into the FIFO at that clock edge.
  - Latency: peak_valid_o high on the cycle after the closing magnitude_ready_i (FIFO empty case).
- FIFO:
  - Show-ahead: head data is valid whenever peak_valid_o=1.
  - Pop when peak_valid_o && peak_ready_i.
  - Push while full is accepted only if a pop occurs in the same cycle.
  - Otherwise the record is dropped and overflow_o sets, cleared only by reset.
  - Simultaneous push and pop with count < FIFO_DEPTH leaves count unchanged.
  - Data outputs hold when peak_ready_i=0.
- frame_done_o: registered pulse the cycle after the magnitude_ready_i with bin FFT_LENGTH-1. Not generated by sync_i.
- No input backpressure: magnitude_ready_i may be asserted every cycle.

Optional Feature:
- PEAK_DC_SKIP_EN.
- Defined: bin 0 is never a peak candidate.
  - Band 0 tracks bins 1..2^BAND_SHIFT-1 only; the first tracked bin loads the accumulator.
  - Bin 0 still advances the bin counter.
- Undefined: bin 0 participates like any other bin.

Test Plan:
- Tones: one frame of 1024 bins, all 0 except bin8=500, bin19=400, bin30=600, bin1016=900; THRESHOLD=64, peak_ready_i=1.
  - Exactly two records: (band0, bin8, 500) then (band1, bin30, 600).
  - Mirror bin 1016 ignored.
  - frame_done_o pulses once, one cycle after bin 1023.
- Tie and threshold: band 2 holds bin33=200 and bin40=200.
  - Record is (2, 33, 200).
  - Band 3 with maximum 64 emits nothing (not strictly greater).
- Backpressure: peak_ready_i=0 for a whole frame in which all 32 bands hold 100.
  - After the frame, FIFO holds bands 0..3; overflow_o=1.
  - Releasing ready yields bands 0,1,2,3 in order, then peak_valid_o=0.
- Sync and reset: feed 37 bins, pulse sync_i, then a full frame with bin5=300.
  - Record is (0, 5, 300).
  - Repeat with reset asserted at bin 37 instead: all outputs 0 the next cycle, overflow_o cleared.
- Back-to-back input: magnitude_ready_i every cycle for 2 frames, bin0=1000 in each, plus one peak >64 in every band.
  - 64 records total; frame_done_o pulses exactly twice.
  - With PEAK_DC_SKIP_EN defined and bin1=70, band 0 reports bin 1 instead of bin 0.
